// File: rtl/thresholding_sched_pkg.sv
// Shared types and helpers for the thresholding scheduler.
package thresholding_sched_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    CONFIG = 2'd2
  } state_t;

  // The output FIFO must hold every in-flight core result plus one: FD >= N + FD_MIN_MARGIN.
  localparam int unsigned FD_MIN_MARGIN = 1;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/thresholding_sched_fifo.sv
// First-word-fall-through FIFO with occupancy count; push into a full FIFO is legal only with a pop.
module thresholding_sched_fifo
  import thresholding_sched_pkg::*;
#(
  parameter  int unsigned W  = 4,
  parameter  int unsigned D  = 6,
  localparam int unsigned AW = clog2_min1(D),
  localparam int unsigned CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(D));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/thresholding_sched.sv
// Valid/ready scheduler around a thresholding core: credit-based input flow, drain-then-configure FSM.
// Optional statistics ports are enabled by defining THRESHOLDING_SCHED_STATS_EN.
module thresholding_sched
  import thresholding_sched_pkg::*;
#(
  parameter  int unsigned N      = 4,
  parameter  int unsigned M      = 8,
  parameter  int unsigned C      = 1,
  parameter  int unsigned O_BITS = N,
  parameter  int unsigned FD     = N + 2,
  localparam int unsigned C_BITS = clog2_min1(C),
  localparam int unsigned A_BITS = $clog2(C) + N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_vld,
  output logic                s_rdy,
  input  logic signed [M-1:0] s_dat,
  output logic                m_vld,
  input  logic                m_rdy,
  output logic [O_BITS-1:0]   m_dat,
  input  logic                cfg_vld,
  output logic                cfg_rdy,
  input  logic                cfg_last,
  input  logic [A_BITS-1:0]   cfg_adr,
  input  logic [M-1:0]        cfg_dat,
  output logic                core_twe,
  output logic [A_BITS-1:0]   core_twa,
  output logic [M-1:0]        core_twd,
  output logic                core_en,
  output logic                core_ivld,
  output logic [C_BITS-1:0]   core_icnl,
  output logic signed [M-1:0] core_idat,
  input  logic                core_ovld,
  input  logic [O_BITS-1:0]   core_odat,
  output logic                busy
`ifdef THRESHOLDING_SCHED_STATS_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [15:0]         cfg_cnt
`endif
);

  localparam int unsigned CW   = $clog2(FD + 1);
  localparam logic [CW:0] FD_L = (CW + 1)'(FD);

  state_t            state;
  logic [C_BITS-1:0] chan;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       used;
  logic              fifo_empty;
  logic              accept;
  logic              cfg_hs;

  // Credits remain while FIFO occupancy plus in-flight samples is below FD.
  assign used    = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign s_rdy   = !rst && (state == RUN) && (used < FD_L) && !cfg_vld;
  assign accept  = s_vld && s_rdy;
  assign cfg_rdy = !rst && (state == CONFIG);
  assign cfg_hs  = cfg_vld && cfg_rdy;
  assign busy    = !rst && (state != RUN);

  assign core_en   = 1'b1;
  assign core_ivld = accept;
  assign core_idat = s_dat;
  assign core_icnl = chan;
  assign core_twe  = cfg_hs;
  assign core_twa  = cfg_adr;
  assign core_twd  = cfg_dat;
  assign m_vld     = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      chan     <= '0;
      inflight <= '0;
    end else begin
      if (accept) chan <= (chan == C_BITS'(C - 1)) ? '0 : chan + 1'b1;
      case ({accept, core_ovld})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
      case (state)
        RUN:     if (cfg_vld) state <= DRAIN;
        DRAIN:   if (inflight == '0) state <= CONFIG;
        CONFIG:  if (cfg_hs && cfg_last) begin
                   state <= RUN;
                   chan  <= '0;
                 end
        default: state <= RUN;
      endcase
    end
  end

  thresholding_sched_fifo #(
    .W (O_BITS),
    .D (FD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (core_ovld),
    .din   (core_odat),
    .pop   (m_vld && m_rdy),
    .dout  (m_dat),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) assert (FD >= N + FD_MIN_MARGIN);
    else     assert (!(core_ovld && !accept && (inflight == '0)));
  end

`ifdef THRESHOLDING_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      cfg_cnt   <= '0;
    end else begin
      if (s_vld && !s_rdy && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (cfg_hs && cfg_last && (cfg_cnt != '1)) cfg_cnt <= cfg_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/thresholding_sched.md
Name: thresholding_sched

Overview:
- Scheduler and handshake wrapper that sits in front of and behind one `thresholding` core instance.
- Converts the core's enable-driven pipeline into AXI-Stream style valid/ready interfaces.
- Generates the folded channel index and arbitrates threshold-configuration writes against live traffic.
- Configuration is only applied once the pipeline has drained, so no in-flight sample ever sees a partially rewritten threshold set.

Parameters:
- N, 4, core output precision; core latency is N cycles.
- M, 8, input/threshold width.
- C, 1, channel count; the channel counter cycles 0..C-1.
- O_BITS, N, output data width, passed through from the core.
- FD, N+2, output FIFO depth; must be >= N+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_vld  in  1  input sample valid.
- s_rdy  out  1  input sample accepted when s_vld && s_rdy.
- s_dat  in  M  signed input sample.
- m_vld  out  1  output valid.
- m_rdy  in  1  downstream ready.
- m_dat  out  O_BITS  thresholded result.
- cfg_vld  in  1  threshold write request.
- cfg_rdy  out  1  write accepted.
- cfg_last  in  1  marks the final write of a burst.
- cfg_adr  in  $clog2(C)+N  core threshold address.
- cfg_dat  in  M  threshold value.
- core_twe  out  1  to core.
- core_twa  out  $clog2(C)+N  to core.
- core_twd  out  M  to core.
- core_en  out  1  to core.
- core_ivld  out  1  to core.
- core_icnl  out  C_BITS  to core.
- core_idat  out  M  to core.
- core_ovld  in  1  from core.
- core_odat  in  O_BITS  from core.
- busy  out  1  high while in DRAIN or CONFIG.

Behaviour:
- Reset values: s_rdy=0, m_vld=0, cfg_rdy=0, core_twe=0, core_ivld=0, busy=0.
- Also cleared on reset: channel counter=0, in-flight counter=0, FIFO empty, state=RUN.
- core_en is held at 1; the pipeline never stalls. Backpressure is handled purely by credits.
- Credits: credit count = FD - (FIFO occupancy + in-flight). In-flight = number of accepted samples not yet emitted by the core.
- s_rdy = (state==RUN) && credits>0 && !cfg_vld. A pending configuration request blocks new inputs.
- Input accept: core_ivld=1, core_idat=s_dat, core_icnl=channel counter (combinational pass-through, no register).
- Channel counter increments on each accept and wraps C-1 -> 0. For C==1 it stays 0.
- Core output: core_ovld pushes core_odat into the FIFO. The credit scheme guarantees no overflow.
  - Overflow is an assertion failure.
  - core_ocnl is ignored.
- Simultaneous accept and emit in one cycle: in-flight count is unchanged.
- FIFO is first-word-fall-through:
  - m_vld = !empty; m_dat = head.
  - Pop on m_vld && m_rdy.
  - Push and pop in the same cycle is allowed at any occupancy, including full.
- FSM:
  - RUN: if cfg_vld -> DRAIN.
  - DRAIN: in-flight==0 -> CONFIG. FIFO contents need not drain and continue to be emitted.
  - CONFIG:
    - cfg_rdy=1.
    - Each handshake drives core_twe=1, core_twa=cfg_adr, core_twd=cfg_dat in the same cycle.
    - Handshake with cfg_last=1 -> RUN and channel counter reset to 0.
- busy = (state != RUN).
- cfg_vld dropping while in DRAIN: still proceed to CONFIG and wait there for the burst to complete. There is no abort path.
- rst asserted mid-burst: return to RUN. Partially written thresholds remain as written; the core's own reset handles its registers.

Optional Feature:
- Macro: THRESHOLDING_SCHED_STATS_EN.
- Defined: adds two output ports.
  - stall_cnt [31:0]: counts cycles with s_vld && !s_rdy.
  - cfg_cnt [15:0]: counts completed bursts.
  - Both saturate and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package thresholding_sched_pkg holds:
  - state enum (RUN, DRAIN, CONFIG);
  - function clog2_min1 for C_BITS;
  - a localparam rule documenting FD >= N+1.
- One sub-module: thresholding_sched_fifo, a parameterised FWFT FIFO (width O_BITS, depth FD) with count output.
- The core is instantiated by the parent wrapper, not inside this block.

Test Plan:
- N=4, C=3, FD=6, continuous s_vld, m_rdy=1 -> one input per cycle; core_icnl sequence 0,1,2,0,1; first m_vld 4 cycles after first accept.
- m_rdy=0 for 20 cycles with continuous input -> exactly 6 accepts then s_rdy=0; FIFO full, no overflow; m_rdy=1 -> 6 outputs in order, throughput resumes.
- cfg_vld asserted with 3 samples in flight -> s_rdy drops the same cycle; the 3 results emerge; cfg_rdy rises only after in-flight=0; 4-word burst produces 4 core_twe pulses with matching twa/twd.
- Burst ending with cfg_last while the channel counter is at 2 -> next accepted sample has core_icnl=0.
- rst asserted in CONFIG after 2 of 4 writes -> next cycle state=RUN, busy=0, m_vld=0, credits=FD.
- With THRESHOLDING_SCHED_STATS_EN: 5 blocked cycles -> stall_cnt=5; two bursts -> cfg_cnt=2.
